// File: rtl/ahb3lite_mem_arbiter.sv
// Two-master arbiter for the single external memory port.
// The CPU master only writes and the CoreSystem master only reads. One master owns the
// port at a time. A per-grant beat limit and alternation on ties give round-robin fairness.
// The owner's beats go straight through to the memory strobes with no added latency.
// Read data comes back from memory one cycle later and is flagged by core_rvalid.
module ahb3lite_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // CPU write master
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_hready,
  // CoreSystem read master
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_hready,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  // Memory port
  output logic [ADDR_W-1:0] mem_READ_addr,
  output logic              mem_read_flag,
  input  logic [DATA_W-1:0] HRDATA_fromMem,
  output logic [ADDR_W-1:0] mem_WRITE_addr,
  output logic              mem_write_flag,
  output logic [DATA_W-1:0] HWDATA_toMem,
  output logic [1:0]        grant_owner
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  // Index of the last beat a grant may take while the other master waits.
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

  // The state encoding matches the grant_owner code, so the state drives that output directly.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGntCpu  = 2'b01,
    StGntCore = 2'b10
  } state_e;

  typedef enum logic {
    OwnCpu  = 1'b0,
    OwnCore = 1'b1
  } owner_e;

  state_e          state_q, state_d;
  owner_e          last_owner_q, last_owner_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            rvalid_q;

  logic            cpu_beat;
  logic            core_beat;

  // A beat is the owner presenting a request. It is accepted in the same cycle.
  assign cpu_beat  = (state_q == StGntCpu) && cpu_req;
  assign core_beat = (state_q == StGntCore) && core_req;

  // Next-state logic: grant from idle, hand over on release or when the beat limit is reached.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      StIdle: begin
        beat_cnt_d = '0;
        if (cpu_req && core_req) begin
          // On a tie, grant the master that did not own the port last.
          state_d = (last_owner_q == OwnCore) ? StGntCpu : StGntCore;
        end else if (cpu_req) begin
          state_d = StGntCpu;
        end else if (core_req) begin
          state_d = StGntCore;
        end
      end
      StGntCpu: begin
        if (!cpu_req) begin
          last_owner_d = OwnCpu;
          beat_cnt_d   = '0;
          state_d      = core_req ? StGntCore : StIdle;
        end else if ((beat_cnt_q == CntMax) && core_req) begin
          // The last allowed beat is taken now. The Core gets the port next cycle with no gap.
          last_owner_d = OwnCpu;
          beat_cnt_d   = '0;
          state_d      = StGntCore;
        end else if (beat_cnt_q != CntMax) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      StGntCore: begin
        if (!core_req) begin
          last_owner_d = OwnCore;
          beat_cnt_d   = '0;
          state_d      = cpu_req ? StGntCpu : StIdle;
        end else if ((beat_cnt_q == CntMax) && cpu_req) begin
          last_owner_d = OwnCore;
          beat_cnt_d   = '0;
          state_d      = StGntCpu;
        end else if (beat_cnt_q != CntMax) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State, fairness bookkeeping and read-valid pipeline.
  // On reset any in-flight read is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= StIdle;
      last_owner_q <= OwnCore;
      beat_cnt_q   <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rvalid_q     <= core_beat;
    end
  end

  // Memory port mux: only the active beat drives its port. The idle port is held at zero.
  always_comb begin
    mem_write_flag = 1'b0;
    mem_WRITE_addr = '0;
    HWDATA_toMem   = '0;
    mem_read_flag  = 1'b0;
    mem_READ_addr  = '0;
    if (cpu_beat) begin
      mem_write_flag = 1'b1;
      mem_WRITE_addr = cpu_addr;
      HWDATA_toMem   = cpu_wdata;
    end
    if (core_beat) begin
      mem_read_flag = 1'b1;
      mem_READ_addr = core_addr;
    end
  end

  // Handshake outputs: a master is stalled only while it requests without owning the port.
  always_comb begin
    cpu_hready  = (state_q == StGntCpu) || !cpu_req;
    core_hready = (state_q == StGntCore) || !core_req;
  end

  assign grant_owner = state_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = HRDATA_fromMem;

endmodule

// File: tb/tb_ahb3lite_mem_arbiter.sv
// Directed bench for ahb3lite_mem_arbiter.
// The bench knows which cycles must carry a beat and checks the memory-port outputs every cycle.
// It queues the expected read data for each Core beat and pops that data when core_rvalid fires.
module tb_ahb3lite_mem_arbiter;

  localparam int unsigned MaxBurst = 4;

  logic        HCLK;
  logic        HRESET;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hready;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_hready;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic [31:0] mem_READ_addr;
  logic        mem_read_flag;
  logic [31:0] hrdata;
  logic [31:0] mem_WRITE_addr;
  logic        mem_write_flag;
  logic [31:0] HWDATA_toMem;
  logic [1:0]  grant_owner;

  int          checks;
  int          errors;
  logic [31:0] sb[$];
  logic [31:0] exp_rd;
  int          cpu_n;
  int          core_n;

  ahb3lite_mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_BURST(MaxBurst)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_hready    (cpu_hready),
    .core_req      (core_req),
    .core_addr     (core_addr),
    .core_hready   (core_hready),
    .core_rdata    (core_rdata),
    .core_rvalid   (core_rvalid),
    .mem_READ_addr (mem_READ_addr),
    .mem_read_flag (mem_read_flag),
    .HRDATA_fromMem(hrdata),
    .mem_WRITE_addr(mem_WRITE_addr),
    .mem_write_flag(mem_write_flag),
    .HWDATA_toMem  (HWDATA_toMem),
    .grant_owner   (grant_owner)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model with 1-cycle read latency.
  initial hrdata = 32'h0;
  always @(posedge HCLK) hrdata <= mem_read_flag ? mem_fn(mem_READ_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-data scoreboard: every rvalid must match the oldest expected read.
  always @(negedge HCLK) begin
    if (core_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {31'h0, core_rvalid}, 32'h0);
      end else begin
        exp_rd = sb.pop_front();
        chk("rdata", core_rdata, exp_rd);
      end
    end
  end

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_ports();
    cpu_addr  = 32'h200 + 32'(cpu_n) * 4;
    cpu_wdata = 32'hC0DE_0000 + 32'(cpu_n);
    core_addr = 32'h800 + 32'(core_n) * 4;
  endtask

  // Check every arbiter output for the current cycle against the expected owner and beats.
  task automatic expect_cycle(input string tag, input logic [1:0] own, input logic cpu_beat,
                              input logic core_beat, input logic push);
    chk($sformatf("%s.owner", tag), {30'h0, grant_owner}, {30'h0, own});
    chk($sformatf("%s.wflag", tag), {31'h0, mem_write_flag}, {31'h0, cpu_beat});
    chk($sformatf("%s.waddr", tag), mem_WRITE_addr, cpu_beat ? cpu_addr : 32'h0);
    chk($sformatf("%s.wdata", tag), HWDATA_toMem, cpu_beat ? cpu_wdata : 32'h0);
    chk($sformatf("%s.rflag", tag), {31'h0, mem_read_flag}, {31'h0, core_beat});
    chk($sformatf("%s.raddr", tag), mem_READ_addr, core_beat ? core_addr : 32'h0);
    chk($sformatf("%s.cpu_hready", tag), {31'h0, cpu_hready},
        {31'h0, (own == 2'b01) || !cpu_req});
    chk($sformatf("%s.core_hready", tag), {31'h0, core_hready},
        {31'h0, (own == 2'b10) || !core_req});
    if (core_beat && push) sb.push_back(mem_fn(core_addr));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cpu_n     = 0;
    core_n    = 0;
    HRESET    = 1'b1;
    cpu_req   = 1'b0;
    core_req  = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    core_addr = 32'h0;

    // 1: reset held for two edges.
    next_cycle();
    next_cycle();
    HRESET = 1'b0;
    #1;
    expect_cycle("reset", 2'b00, 1'b0, 1'b0, 1'b1);
    chk("reset.rvalid", {31'h0, core_rvalid}, 32'h0);

    // 2: single CPU write.
    next_cycle();
    cpu_req   = 1'b1;
    cpu_addr  = 32'h100;
    cpu_wdata = 32'hDEAD_BEEF;
    #1;
    expect_cycle("wr.c0", 2'b00, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1;
    expect_cycle("wr.c1", 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle();
    cpu_req = 1'b0;
    #1;
    expect_cycle("wr.c2", 2'b01, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1;
    expect_cycle("wr.c3", 2'b00, 1'b0, 1'b0, 1'b1);

    // 3: three Core reads at 0x40, 0x44 and 0x48.
    next_cycle();
    core_req  = 1'b1;
    core_addr = 32'h40;
    #1;
    expect_cycle("rd.c0", 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      core_addr = 32'h40 + 32'(i) * 4;
      #1;
      expect_cycle($sformatf("rd.c%0d", i + 1), 2'b10, 1'b0, 1'b1, 1'b1);
    end
    next_cycle();
    core_req = 1'b0;
    #1;
    expect_cycle("rd.c4", 2'b10, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1;
    expect_cycle("rd.c5", 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rd.drained", 32'(sb.size()), 32'h0);

    // 4: both masters request from reset. Bursts of MaxBurst alternate with no idle cycle.
    next_cycle();
    HRESET   = 1'b1;
    cpu_req  = 1'b1;
    core_req = 1'b1;
    drive_ports();
    #1;
    expect_cycle("ct.rst", 2'b00, 1'b0, 1'b0, 1'b1);
    next_cycle();
    HRESET = 1'b0;
    #1;
    expect_cycle("ct.idle", 2'b00, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < int'(MaxBurst); b++) begin
        next_cycle();
        drive_ports();
        #1;
        if (r % 2 == 0) begin
          expect_cycle($sformatf("ct.r%0d.b%0d", r, b), 2'b01, 1'b1, 1'b0, 1'b1);
          cpu_n++;
        end else begin
          expect_cycle($sformatf("ct.r%0d.b%0d", r, b), 2'b10, 1'b0, 1'b1, 1'b1);
          core_n++;
        end
      end
    end

    // 5: the CPU releases early after 2 beats. The Core then gets a full burst.
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      drive_ports();
      #1;
      expect_cycle($sformatf("er.cpu%0d", b), 2'b01, 1'b1, 1'b0, 1'b1);
      cpu_n++;
    end
    next_cycle();
    cpu_req = 1'b0;
    drive_ports();
    #1;
    expect_cycle("er.release", 2'b01, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < int'(MaxBurst); b++) begin
      next_cycle();
      cpu_req = 1'b1;
      drive_ports();
      #1;
      expect_cycle($sformatf("er.core%0d", b), 2'b10, 1'b0, 1'b1, 1'b1);
      core_n++;
    end
    next_cycle();
    drive_ports();
    #1;
    expect_cycle("er.back", 2'b01, 1'b1, 1'b0, 1'b1);
    cpu_n++;

    // 6: reset arrives while a Core read is in flight. That read must not produce rvalid.
    next_cycle();
    cpu_req = 1'b0;
    drive_ports();
    #1;
    expect_cycle("rm.release", 2'b01, 1'b0, 1'b0, 1'b1);
    next_cycle();
    HRESET = 1'b1;
    drive_ports();
    #1;
    expect_cycle("rm.beat", 2'b10, 1'b0, 1'b1, 1'b0);
    next_cycle();
    HRESET  = 1'b0;
    cpu_req = 1'b1;
    core_n++;
    drive_ports();
    #1;
    expect_cycle("rm.idle", 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rm.rvalid", {31'h0, core_rvalid}, 32'h0);
    next_cycle();
    #1;
    expect_cycle("rm.tie", 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle();
    cpu_req  = 1'b0;
    core_req = 1'b0;
    #1;
    expect_cycle("rm.end", 2'b01, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1;
    expect_cycle("rm.idle2", 2'b00, 1'b0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    chk("sb.empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
